// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a small melody stored in NUM_NOTES slot registers. Each slot holds
//   {half_period[30:10], duration_ms[9:0]}. For every slot the sequencer loads
//   the half-period onto `delay`, enables the downstream tone generator for
//   duration_ms milliseconds (half_period == 0 is a rest), then inserts a
//   silent gap of GAP_MS milliseconds before moving on to the next slot.
//
//   Parameters:
//     NUM_NOTES - number of melody slots (2..8)
//     TICK_DIV  - CLOCK_50 cycles per 1 ms tick
//     GAP_MS    - silent gap after each note, in ms (0 = no gap)
//
//   Ports:
//     CLOCK_50   in   sole clock, rising edge
//     reset      in   asynchronous active-high reset
//     start      in   begin playback from slot 0 (honoured only when idle)
//     stop       in   abort playback, back to idle, no done pulse
//     note_we    in   slot write strobe (honoured only when idle)
//     note_addr  in   slot index for write
//     note_data  in   {half_period, duration_ms}
//     delay      out  half-period count for the tone generator
//     tone_en    out  tone generator enable
//     note_idx   out  slot currently playing
//     busy       out  high whenever not idle
//     done       out  one-cycle pulse when the melody ends
//
//   Build option:
//     NOTE_SEQ_LOOP_EN - when defined, playback wraps from the last slot back
//                        to slot 0 (done still pulses on each wrap) until stop
//                        or reset.
module note_sequencer #(
  parameter int NUM_NOTES = 8,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_MS    = 20
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        note_we,
  input  logic [2:0]  note_addr,
  input  logic [30:0] note_data,
  output logic [20:0] delay,
  output logic        tone_en,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int                 TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [9:0]         GAP_LAST  = 10'(GAP_MS - 1);
  localparam logic [2:0]         LAST_IDX  = 3'(NUM_NOTES - 1);
  localparam logic [3:0]         NUM_SLOTS = 4'(NUM_NOTES);

  // Storage is always 8 deep so the 3-bit index never runs off the array;
  // slots at or above NUM_NOTES are never written and stay at zero.
  logic [30:0]       slot_q [0:7];

  logic [2:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [20:0]       delay_q, delay_d;
  logic [9:0]        dur_q, dur_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [9:0]        ms_q, ms_d;
  logic              tone_q, tone_d;
  logic              done_q, done_d;

  logic [30:0]       cur_slot;
  logic              advance;
  logic              slot_wr;

  assign cur_slot = slot_q[idx_q];
  assign slot_wr  = note_we && (state_q == S_IDLE) && ({1'b0, note_addr} < NUM_SLOTS);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    delay_d = delay_q;
    dur_d   = dur_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        delay_d = cur_slot[30:10];
        dur_d   = cur_slot[9:0];
        tick_d  = '0;
        ms_d    = '0;
        if (cur_slot[9:0] == 10'd0) begin
          advance = 1'b1;
        end else begin
          state_d = S_PLAY;
          tone_d  = |cur_slot[30:10];
        end
      end
      S_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (ms_q == dur_q - 10'd1) begin
            ms_d   = '0;
            tone_d = 1'b0;
            if (GAP_MS == 0) advance = 1'b1;
            else             state_d = S_GAP;
          end else begin
            ms_d = ms_q + 10'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (ms_q == GAP_LAST) begin
            ms_d    = '0;
            advance = 1'b1;
          end else begin
            ms_d = ms_q + 10'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
      end
    endcase

    // Shared next-slot decision, reached from LOAD (zero duration),
    // PLAY (no gap configured) or GAP.
    if (advance) begin
      tone_d = 1'b0;
      if (idx_q < LAST_IDX) begin
        idx_d   = idx_q + 3'd1;
        state_d = S_LOAD;
      end else begin
`ifdef NOTE_SEQ_LOOP_EN
        idx_d   = '0;
        state_d = S_LOAD;
        done_d  = 1'b1;
`else
        state_d = S_DONE;
        done_d  = 1'b1;
`endif
      end
    end

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tone_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      delay_q <= '0;
      dur_q   <= '0;
      tick_q  <= '0;
      ms_q    <= '0;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      delay_q <= delay_d;
      dur_q   <= dur_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) slot_q[i] <= '0;
    end else if (slot_wr) begin
      slot_q[note_addr] <= note_data;
    end
  end

  assign delay    = delay_q;
  assign tone_en  = tone_q;
  assign note_idx = idx_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stop, note_we;
  logic [2:0]  note_addr;
  logic [30:0] note_data;
  logic [20:0] delay;
  logic        tone_en, busy, done;
  logic [2:0]  note_idx;

  int checks = 0;
  int failures = 0;

  int unsigned exp_hp  [4];
  int unsigned exp_dur [4];
  int unsigned exp_dly;

  always #5 clk = ~clk;

  note_sequencer #(.NUM_NOTES(4), .TICK_DIV(4), .GAP_MS(1)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .note_we   (note_we),
    .note_addr (note_addr),
    .note_data (note_data),
    .delay     (delay),
    .tone_en   (tone_en),
    .note_idx  (note_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks n consecutive cycles (at negedges) of one phase, then advances.
  task automatic seg(input string tag, input int n, input logic tone,
                     input int unsigned dly, input int unsigned idx);
    for (int k = 0; k < n; k++) begin
      chk({tag, ".tone"}, 32'(tone_en), 32'(tone));
      chk({tag, ".delay"}, 32'(delay), dly);
      chk({tag, ".idx"}, 32'(note_idx), idx);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".done"}, 32'(done), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic wr(input int unsigned a, input int unsigned hp, input int unsigned dur);
    note_addr = 3'(a);
    note_data = {21'(hp), 10'(dur)};
    note_we   = 1'b1;
    @(negedge clk);
    note_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference model of one full pass: LOAD 1 cycle, PLAY dur*4, GAP 4.
  task automatic play_melody(input string tag);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      seg({tag, ".load"}, 1, 1'b0, exp_dly, i);
      exp_dly = exp_hp[i];
      if (exp_dur[i] != 0) begin
        seg({tag, ".play"}, int'(exp_dur[i]) * 4, (exp_hp[i] != 0), exp_hp[i], i);
        seg({tag, ".gap"}, 4, 1'b0, exp_hp[i], i);
      end
    end
`ifdef NOTE_SEQ_LOOP_EN
    chk({tag, ".wrap_done"}, 32'(done), 32'd1);
    chk({tag, ".wrap_busy"}, 32'(busy), 32'd1);
    chk({tag, ".wrap_idx"}, 32'(note_idx), 32'd0);
    @(negedge clk);
    chk({tag, ".wrap_tone"}, 32'(tone_en), 32'(exp_hp[0] != 0 && exp_dur[0] != 0));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk({tag, ".stop_busy"}, 32'(busy), 32'd0);
`else
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_busy"}, 32'(busy), 32'd1);
    chk({tag, ".done_tone"}, 32'(tone_en), 32'd0);
    chk({tag, ".done_idx"}, 32'(note_idx), 32'd3);
    @(negedge clk);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; note_we = 1'b0;
    note_addr = '0; note_data = '0;
    exp_dly = 0;
    repeat (2) @(negedge clk);
    chk("rst.delay", 32'(delay), 32'd0);
    chk("rst.tone", 32'(tone_en), 32'd0);
    chk("rst.idx", 32'(note_idx), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic melody
    exp_hp  = '{95419, 42589, 37936, 95419};
    exp_dur = '{2, 1, 1, 1};
    for (int i = 0; i < 4; i++) wr(i, exp_hp[i], exp_dur[i]);
    play_melody("mel");

    // Rest in slot 1
    exp_hp[1] = 0; exp_dur[1] = 2;
    wr(1, 0, 2);
    play_melody("rest");

    // Zero-duration slot 2 is skipped
    exp_hp[1] = 42589; exp_dur[1] = 1;
    exp_dur[2] = 0;
    wr(1, 42589, 1);
    wr(2, 37936, 0);
    play_melody("skip");

    // start+stop together in idle stays idle
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss.busy", 32'(busy), 32'd0);

    // Stop mid-PLAY of slot 1; write and start while busy are ignored
    pulse_start();
    repeat (14) @(negedge clk);
    chk("stp.idx", 32'(note_idx), 32'd1);
    chk("stp.tone", 32'(tone_en), 32'd1);
    chk("stp.delay", 32'(delay), 32'd42589);
    note_addr = 3'd0; note_data = {21'd1234, 10'd3}; note_we = 1'b1; start = 1'b1;
    @(negedge clk);
    note_we = 1'b0; start = 1'b0;
    chk("busy_start.idx", 32'(note_idx), 32'd1);
    chk("busy_start.tone", 32'(tone_en), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stp.busy", 32'(busy), 32'd0);
    chk("stp.tone0", 32'(tone_en), 32'd0);
    chk("stp.done", 32'(done), 32'd0);
    @(negedge clk);
    chk("stp.done2", 32'(done), 32'd0);
    chk("stp.busy2", 32'(busy), 32'd0);
    exp_dly = 42589;
    play_melody("nowr");

    // Asynchronous reset mid-GAP clears outputs and slots
    pulse_start();
    repeat (9) @(negedge clk);
    chk("gap.tone", 32'(tone_en), 32'd0);
    chk("gap.busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst.delay", 32'(delay), 32'd0);
    chk("arst.tone", 32'(tone_en), 32'd0);
    chk("arst.idx", 32'(note_idx), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_hp = '{0, 0, 0, 0};
    exp_dur = '{0, 0, 0, 0};
    exp_dly = 0;
    play_melody("zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter NUM_NOTES, default 8, number of melody slots (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 50000, CLOCK_50 cycles per 1 ms tick.
REQ-003 SHALL have parameter GAP_MS, default 20, silent gap in ms after each note.
REQ-004 SHALL have port CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin playback from slot 0 (sampled in IDLE only).
REQ-007 SHALL have port stop  in  1  abort playback, return to IDLE.
REQ-008 SHALL have port note_we  in  1  slot write strobe.
REQ-009 SHALL have port note_addr  in  3  slot index for write.
REQ-010 SHALL have port note_data  in  31  {half_period[30:10], duration_ms[9:0]}.
REQ-011 SHALL have port delay  out  21  half-period count for downstream square-wave tone generator.
REQ-012 SHALL have port tone_en  out  1  downstream tone enable.
REQ-013 SHALL have port note_idx  out  3  slot currently playing.
REQ-014 SHALL have port busy  out  1  high in any state except IDLE.
REQ-015 SHALL have port done  out  1  one-cycle pulse when melody ends.

Function
REQ-016 SHALL hold NUM_NOTES x 31-bit slot registers; note_we with note_addr < NUM_NOTES writes when IDLE; writes while busy or with out-of-range addr are ignored.
REQ-017 SHALL implement states IDLE, LOAD, PLAY, GAP, DONE.
REQ-018 IDLE: start=1 -> LOAD with note_idx=0 next cycle; else stay.
REQ-019 LOAD (1 cycle): latch slot[note_idx] into delay/duration regs; duration_ms=0 -> skip straight to next-slot decision (REQ-022); else -> PLAY.
REQ-020 PLAY: tone_en=1 unless half_period=0 (rest, tone_en=0); lasts exactly duration_ms*TICK_DIV cycles, tick and ms counters cleared on entry; then -> GAP.
REQ-021 GAP: tone_en=0, delay held; lasts exactly GAP_MS*TICK_DIV cycles (GAP_MS=0 -> zero-length, decision taken at PLAY exit); then next-slot decision.
REQ-022 Next-slot decision: note_idx < NUM_NOTES-1 -> increment, LOAD; else -> DONE (or per REQ-029).
REQ-023 DONE (1 cycle): done=1, tone_en=0, -> IDLE.
REQ-024 stop=1 in any non-IDLE state -> IDLE next cycle, tone_en=0, no done pulse; stop has priority over all other transitions.
REQ-025 start while busy SHALL be ignored; start and stop together in IDLE: stay IDLE.
REQ-026 Latency: start asserted at edge N -> LOAD at N+1 -> PLAY (tone_en=1, delay valid) at N+2.
REQ-027 Duration counter SHALL be 10-bit ms count plus tick counter sized for TICK_DIV-1; no wrap within a note.

Reset
REQ-028 On reset: state IDLE, delay=0, tone_en=0, note_idx=0, busy=0, done=0, counters 0, all slots 0; released reset takes effect at next edge only.

Configuration
REQ-029 With macro NOTE_SEQ_LOOP_EN defined: after last slot's GAP, done pulses one cycle while state goes directly to LOAD with note_idx=0 (no DONE/IDLE); only stop or reset ends playback. Undefined: REQ-022/023 behaviour, single pass.

Verification (TICK_DIV=4, GAP_MS=1, NUM_NOTES=4)
REQ-030 Write slots {95419,2},{42589,1},{37936,1},{95419,1}; pulse start -> tone_en high 8 cycles with delay=95419, low 4, then 4/4 for each later note, done pulse after last gap, busy low next cycle.
REQ-031 Slot 1 half_period=0, duration 2 -> tone_en low for 8+4 cycles, note_idx=1 throughout, delay=0.
REQ-032 Slot 2 duration 0 -> note_idx jumps 1->2->3 with no PLAY cycles for slot 2.
REQ-033 stop mid-PLAY of slot 1 -> IDLE next cycle, tone_en=0, busy=0, no done; note_we during busy leaves slot unchanged.
REQ-034 reset asserted mid-GAP -> outputs zero immediately (asynchronously), all slots read back 0.
REQ-035 NOTE_SEQ_LOOP_EN defined -> after slot 3 gap, done pulses and note_idx=0 PLAY resumes without busy dropping.
